// File: rtl/life_grid_scanner.sv
// Row-multiplexed 8x8 LED scanner for Game of Life generations; swaps generations only at frame boundaries.
// Optional macro SCAN_BLANK_EN inserts one dark BLANK cycle after every row.
//
// state | meaning
// IDLE  | dark, waiting for the first generation
// SCAN  | row row_q lit, dwell_q cycles remaining after this one
// BLANK | dark gap after a row (SCAN_BLANK_EN only)
module life_grid_scanner #(
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] grid,
  input  logic        grid_valid,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        frame_done,
  output logic        overrun,
  output logic [15:0] gen_count,
  output logic [6:0]  alive_count
);

  localparam int DW = $clog2(DWELL + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;

  state_t        state_q, state_d;
  logic [2:0]    row_q, row_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [63:0]   shadow_q, shadow_d;
  logic [63:0]   pending_q, pending_d;
  logic          pending_valid_q, pending_valid_d;
  logic [7:0]    row_sel_q, row_sel_d;
  logic [7:0]    col_data_q, col_data_d;
  logic          frame_done_q, frame_done_d;
  logic          overrun_q, overrun_d;
  logic [15:0]   gen_count_q, gen_count_d;
  logic [6:0]    alive_count_q, alive_count_d;

  logic          at_boundary;
  logic          load;
  logic [63:0]   load_val;

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n = n + 7'(v[i]);
    return n;
  endfunction

  always_comb begin
    state_d         = state_q;
    row_d           = row_q;
    dwell_d         = dwell_q;
    shadow_d        = shadow_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    gen_count_d     = gen_count_q;
    alive_count_d   = alive_count_q;
    overrun_d       = 1'b0;
    load            = 1'b0;
    load_val        = shadow_q;

`ifdef SCAN_BLANK_EN
    at_boundary = (state_q == BLANK) && (row_q == 3'd7);
`else
    at_boundary = (state_q == SCAN) && (row_q == 3'd7) && (dwell_q == '0);
`endif

    case (state_q)
      IDLE: begin
        if (grid_valid) begin
          load     = 1'b1;
          load_val = grid;
          state_d  = SCAN;
          row_d    = 3'd0;
          dwell_d  = DWELL_LAST;
        end
      end
      SCAN: begin
        if (dwell_q != '0) begin
          dwell_d = dwell_q - DW'(1);
        end else begin
`ifdef SCAN_BLANK_EN
          state_d = BLANK;
`else
          row_d   = row_q + 3'd1;
          dwell_d = DWELL_LAST;
`endif
        end
      end
`ifdef SCAN_BLANK_EN
      BLANK: begin
        state_d = SCAN;
        row_d   = row_q + 3'd1;
        dwell_d = DWELL_LAST;
      end
`endif
      default: state_d = IDLE;
    endcase

    // A strobe on the boundary bypasses pending; anything still pending is lost.
    if (state_q != IDLE) begin
      if (at_boundary) begin
        if (grid_valid) begin
          load            = 1'b1;
          load_val        = grid;
          overrun_d       = pending_valid_q;
          pending_valid_d = 1'b0;
        end else if (pending_valid_q) begin
          load            = 1'b1;
          load_val        = pending_q;
          pending_valid_d = 1'b0;
        end
      end else if (grid_valid) begin
        pending_d       = grid;
        pending_valid_d = 1'b1;
        overrun_d       = pending_valid_q;
      end
    end

    if (load) begin
      shadow_d      = load_val;
      gen_count_d   = gen_count_q + 16'd1;
      alive_count_d = popcount64(load_val);
    end

    row_sel_d  = 8'h00;
    col_data_d = 8'h00;
    if (state_d == SCAN) begin
      row_sel_d  = 8'd1 << row_d;
      col_data_d = shadow_d[{row_d, 3'b000} +: 8];
    end

`ifdef SCAN_BLANK_EN
    frame_done_d = (state_d == BLANK) && (row_d == 3'd7);
`else
    frame_done_d = (state_d == SCAN) && (row_d == 3'd7) && (dwell_d == '0);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      row_q           <= '0;
      dwell_q         <= '0;
      shadow_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      row_sel_q       <= '0;
      col_data_q      <= '0;
      frame_done_q    <= 1'b0;
      overrun_q       <= 1'b0;
      gen_count_q     <= '0;
      alive_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      dwell_q         <= dwell_d;
      shadow_q        <= shadow_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      row_sel_q       <= row_sel_d;
      col_data_q      <= col_data_d;
      frame_done_q    <= frame_done_d;
      overrun_q       <= overrun_d;
      gen_count_q     <= gen_count_d;
      alive_count_q   <= alive_count_d;
    end
  end

  assign row_sel     = row_sel_q;
  assign col_data    = col_data_q;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;
  assign gen_count   = gen_count_q;
  assign alive_count = alive_count_q;

endmodule

// File: tb/tb_life_grid_scanner.sv
// Directed bench for life_grid_scanner: frame scan, pending/overrun handling, async reset.
module tb_life_grid_scanner;

  localparam int DWELL = 4;
`ifdef SCAN_BLANK_EN
  localparam int ROW_LEN = DWELL + 1;
`else
  localparam int ROW_LEN = DWELL;
`endif
  localparam int FRAME = 8 * ROW_LEN;

  localparam logic [63:0] G1 = 64'h0412_6424_0034_3C28; // 17 live
  localparam logic [63:0] GF = 64'hFFFF_FFFF_FFFF_FFFF; // 64 live
  localparam logic [63:0] GA = 64'h8040_2010_0804_0201; // 8 live
  localparam logic [63:0] GB = 64'h00FF_0000_FF00_0F0F; // 24 live
  localparam logic [63:0] GC = 64'h3C42_8181_8181_423C; // 20 live

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] grid;
  logic        grid_valid;
  logic [7:0]  row_sel;
  logic [7:0]  col_data;
  logic        frame_done;
  logic        overrun;
  logic [15:0] gen_count;
  logic [6:0]  alive_count;

  int n_chk = 0;
  int n_bad = 0;

  life_grid_scanner #(.DWELL(DWELL)) dut (
    .clk         (clk),
    .reset       (reset),
    .grid        (grid),
    .grid_valid  (grid_valid),
    .row_sel     (row_sel),
    .col_data    (col_data),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .gen_count   (gen_count),
    .alive_count (alive_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dark(input string tag);
    check_eq({tag, " row_sel"},     64'(row_sel),     64'h0);
    check_eq({tag, " col_data"},    64'(col_data),    64'h0);
    check_eq({tag, " frame_done"},  64'(frame_done),  64'h0);
    check_eq({tag, " overrun"},     64'(overrun),     64'h0);
    check_eq({tag, " gen_count"},   64'(gen_count),   64'h0);
    check_eq({tag, " alive_count"}, 64'(alive_count), 64'h0);
  endtask

  // Entered at cycle 0 of a frame (1ns after its first edge); leaves at cycle 0 of the next.
  task automatic frame_check(input string name, input logic [63:0] exp_grid,
                             input int exp_gen, input int exp_alive,
                             input int s1, input logic [63:0] g1,
                             input int s2, input logic [63:0] g2,
                             input int exp_ov);
    logic [7:0] one;
    logic [7:0] exp_row;
    logic [7:0] exp_col;
    int r;
    int ph;
    one = 8'h01;
    for (int k = 0; k < FRAME; k++) begin
      r  = k / ROW_LEN;
      ph = k % ROW_LEN;
      exp_row = (ph < DWELL) ? (one << r) : 8'h00;
      exp_col = (ph < DWELL) ? exp_grid[8*r +: 8] : 8'h00;
      check_eq($sformatf("%s c%0d row_sel", name, k), 64'(row_sel), 64'(exp_row));
      check_eq($sformatf("%s c%0d col_data", name, k), 64'(col_data), 64'(exp_col));
      check_eq($sformatf("%s c%0d frame_done", name, k), 64'(frame_done), 64'(k == FRAME - 1));
      check_eq($sformatf("%s c%0d overrun", name, k), 64'(overrun), 64'(k == exp_ov));
      if (k == 0) begin
        check_eq({name, " gen_count"}, 64'(gen_count), 64'(exp_gen));
        check_eq({name, " alive_count"}, 64'(alive_count), 64'(exp_alive));
      end
      if (k == s1) begin
        grid = g1; grid_valid = 1'b1;
      end else if (k == s2) begin
        grid = g2; grid_valid = 1'b1;
      end else begin
        grid_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    grid_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    grid = '0;
    grid_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_dark("in_reset");
    reset = 1'b0;

    repeat (3) begin
      @(posedge clk); #1;
      check_eq("idle row_sel", 64'(row_sel), 64'h0);
      check_eq("idle gen_count", 64'(gen_count), 64'h0);
    end

    grid = G1; grid_valid = 1'b1;
    @(posedge clk); #1;
    grid_valid = 1'b0;

    frame_check("f1_g1",      G1, 1, 17, 10, GF, -1, 64'h0, -1);
    frame_check("f2_ff",      GF, 2, 64, 5,  GA, 12, GB,    13);
    frame_check("f3_b",       GB, 3, 24, 7,  GA, FRAME - 1, GC, -1);
    frame_check("f4_c",       GC, 4, 20, -1, 64'h0, -1, 64'h0, 0);
    frame_check("f5_rescan",  GC, 4, 20, -1, 64'h0, -1, 64'h0, -1);

    repeat (3 * ROW_LEN + 1) @(posedge clk);
    #1;
    check_eq("pre_reset row_sel", 64'(row_sel), 64'h08);
    #2 reset = 1'b1;
    #1;
    check_dark("async_reset");
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check_eq("post_reset row_sel", 64'(row_sel), 64'h0);
      check_eq("post_reset gen_count", 64'(gen_count), 64'h0);
    end

    grid = G1; grid_valid = 1'b1;
    @(posedge clk); #1;
    grid_valid = 1'b0;
    frame_check("f6_restart", G1, 1, 17, -1, 64'h0, -1, 64'h0, -1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/life_grid_scanner.md
# life_grid_scanner

Downstream display stage for the 8x8 Game of Life datapath. Consumes each 64-bit generation produced by the life control/evolve block and drives a row-multiplexed 8x8 LED matrix. The block holds the displayed generation in a shadow register and buffers at most one newer generation. It swaps generations only at frame boundaries, so a frame never tears, and it reports generation count and live-cell population.

## Interface
- DWELL, default 4: cycles each row is lit; legal range 1..1023.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- grid  in  64  generation from upstream; row r = grid[8r+7:8r], column c = bit c of that row.
- grid_valid  in  1  one-cycle strobe marking grid as a new generation.
- row_sel  out  8  one-hot active row; 8'h00 when dark.
- col_data  out  8  column bits of the active row; 8'h00 when dark.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame.
- overrun  out  1  one-cycle pulse when a buffered generation is discarded unshown.
- gen_count  out  16  number of generations loaded into the shadow register; wraps 16'hFFFF to 16'h0000.
- alive_count  out  7  population of the shadow generation (0..64).

## Operation
- State machine:
  - IDLE: dark, waiting for the first generation.
  - SCAN: row r lit for DWELL cycles.
  - BLANK: only present with the configuration macro.
- Reset (any time, including mid-frame):
  - State returns to IDLE; all outputs are 0.
  - shadow, pending and pending_valid are cleared.
  - Row and dwell counters are cleared.
- IDLE + grid_valid: load grid into shadow, go to SCAN row 0, gen_count +1, alive_count = popcount(grid).
- SCAN:
  - row_sel = 1<<r; col_data = shadow[8r+7:8r].
  - After DWELL cycles, advance r; after row 7, wrap to row 0 (frame boundary).
- grid_valid during a frame, not at a frame boundary:
  - grid is written to pending and pending_valid is set.
  - If pending_valid was already set, the old pending is overwritten and overrun pulses.
- At a frame boundary (end of the frame_done cycle), the first matching rule applies:
  - grid_valid high: load grid directly into shadow. If pending_valid was set, discard pending and pulse overrun.
  - Else pending_valid set: load pending into shadow and clear pending_valid.
  - Else: keep shadow and rescan it. gen_count and alive_count are unchanged.
- Every shadow load increments gen_count and registers alive_count from the loaded value.
- The display refreshes continuously. The block never returns to IDLE except via reset.

## Timing
- IDLE + grid_valid high at edge N:
  - row_sel = 8'h01 from the cycle after edge N.
  - gen_count and alive_count are updated in that same cycle.
- Frame length without the macro: 8*DWELL cycles.
- frame_done is high during the final dwell cycle of row 7.
- A newly loaded shadow is first visible on row 0 of the following frame, which starts in the cycle after the boundary.
- overrun is asserted in the cycle after the discarding edge.
- DWELL=1: the row advances every cycle and frame_done is high every 8th cycle.
- Dwell counter width: clog2(DWELL+1) bits. No other arithmetic exceeds declared widths.

## Configuration
- SCAN_BLANK_EN defined:
  - After each row's DWELL cycles, insert one BLANK cycle (row_sel = 8'h00, col_data = 8'h00) to suppress ghosting.
  - Frame length becomes 8*(DWELL+1) cycles.
  - frame_done moves to the BLANK cycle after row 7.
  - All boundary rules apply at the end of that cycle.
- SCAN_BLANK_EN undefined: no BLANK state; rows are contiguous.

## Test plan
- Reset, then one strobe with grid=64'h0412_6424_0034_3C28, DWELL=4:
  - col_data per row is 28,3C,34,00,24,64,12,04 (hex).
  - Each row lasts 4 cycles.
  - alive_count=17, gen_count=1.
  - frame_done pulses every 32 cycles.
- Mid-frame strobe with grid=64'hFFFF_FFFF_FFFF_FFFF:
  - The current frame finishes unchanged.
  - The next frame shows FF on every row; alive_count=64, gen_count=2.
- Two mid-frame strobes (A, then B) within one frame:
  - overrun pulses once.
  - The next frame shows B and gen_count increments by 1.
- Strobe coincident with frame_done while pending holds A:
  - The new grid is shown next; A is discarded and overrun pulses.
- Reset asserted asynchronously mid-row 3:
  - All outputs read 0 immediately.
  - After release, the block stays dark until the next grid_valid.
- SCAN_BLANK_EN with DWELL=2:
  - row_sel sequence per row: 01,01,00 (hex), then 02,02,00, and so on through row 7.
  - Frame length is 24 cycles; frame_done is on cycle 24.
